// File: rtl/phase3_sweep_unit_pkg.sv
// Shared definitions for the phase-3 sweep sequencer and its neighbours.
package phase3_sweep_unit_pkg;

  // Default geometry shared with the position/velocity caches and the control unit.
  localparam int N_CELL_DEF     = 27;
  localparam int CELL_DEPTH_DEF = 64;
  localparam int RD_LAT_DEF     = 2;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/phase3_sweep_unit_read_tag_pipe.sv
// Tag shift register that follows each cache read through the fixed read
// latency, so the returning occupancy bit can be matched to its cell/slot.
module phase3_sweep_unit_read_tag_pipe
  import phase3_sweep_unit_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CELL_W = 5,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [CELL_W-1:0] push_cell,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              ret_valid,
  output logic [CELL_W-1:0] ret_cell,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              pipe_empty
);

  logic              vld_q  [RD_LAT];
  logic              vld_d  [RD_LAT];
  logic [CELL_W-1:0] cell_q [RD_LAT];
  logic [CELL_W-1:0] cell_d [RD_LAT];
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];

  // Shift every tag one stage deeper; stage 0 takes the read issued this cycle.
  always_comb begin
    vld_d[0]  = push_valid;
    cell_d[0] = push_cell;
    addr_d[0] = push_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      cell_d[i] = cell_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  // Tag registers; reset drops every outstanding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        cell_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_d[i];
        cell_q[i] <= cell_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  // No read is in flight when every stage is invalid.
  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      if (vld_q[i]) pipe_empty = 1'b0;
    end
  end

  // The last stage lines up with the cache's returned occupancy bit.
  assign ret_valid = vld_q[RD_LAT-1];
  assign ret_cell  = cell_q[RD_LAT-1];
  assign ret_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/phase3_sweep_unit.sv
// Phase-3 (motion update) sequencer: on each armed phase3_ready rise it reads
// every slot of every cell from the latched read bank, forwards occupied slots
// to the update datapath, waits for the datapath to drain and pulses done.
// A cell ends at its first empty slot; reads of that cell already in flight
// are squashed when they return.
module phase3_sweep_unit
  import phase3_sweep_unit_pkg::*;
#(
  parameter int N_CELL     = N_CELL_DEF,
  parameter int CELL_DEPTH = CELL_DEPTH_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int CELL_W     = $clog2(N_CELL),
  parameter int ADDR_W     = $clog2(CELL_DEPTH),
  parameter int CNT_W      = $clog2(N_CELL*CELL_DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phase3_ready,
  input  logic              double_buffer,
  output logic              phase3_done,
  output logic              rd_en,
  output logic [CELL_W-1:0] rd_cell,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  input  logic              rd_slot_valid,
  output logic              upd_valid,
  output logic [CELL_W-1:0] upd_cell,
  output logic [ADDR_W-1:0] upd_addr,
  output logic              wr_bank,
  input  logic              wb_idle,
  output logic [CNT_W-1:0]  particle_count
);

  localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(N_CELL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_DEPTH - 1);

  sweep_state_e      state_q, state_d;
  logic              armed_q, armed_d;
  logic              bank_q, bank_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CELL-1:0] term_q, term_d;
  logic              upd_valid_q, upd_valid_d;
  logic [CELL_W-1:0] upd_cell_q, upd_cell_d;
  logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
  logic [CNT_W-1:0]  pcount_q, pcount_d;

  logic              issue;
  logic              ret_valid;
  logic [CELL_W-1:0] ret_cell;
  logic [ADDR_W-1:0] ret_addr;
  logic              pipe_empty;
  logic              ret_empty;
  logic              ret_hit;
  logic              cell_cut;

  assign issue = (state_q == ST_SWEEP);

  phase3_sweep_unit_read_tag_pipe #(
    .RD_LAT (RD_LAT),
    .CELL_W (CELL_W),
    .ADDR_W (ADDR_W)
  ) u_read_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .push_valid (issue),
    .push_cell  (cell_q),
    .push_addr  (addr_q),
    .ret_valid  (ret_valid),
    .ret_cell   (ret_cell),
    .ret_addr   (ret_addr),
    .pipe_empty (pipe_empty)
  );

  // Classify the returning read: an empty slot ends its cell, an occupied
  // slot is forwarded unless its cell has already ended.
  always_comb begin
    ret_empty = ret_valid && !rd_slot_valid;
    ret_hit   = ret_valid && rd_slot_valid && !term_q[ret_cell];
    cell_cut  = (ret_empty && (ret_cell == cell_q)) || (addr_q == LAST_ADDR);
  end

  // Next-state, issue pointer, squash set and running count.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q || !phase3_ready;
    bank_d      = bank_q;
    cell_d      = cell_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    term_d      = term_q;
    upd_valid_d = 1'b0;
    upd_cell_d  = upd_cell_q;
    upd_addr_d  = upd_addr_q;
    pcount_d    = pcount_q;

    if (ret_empty) begin
      term_d[ret_cell] = 1'b1;
    end
    if (ret_hit) begin
      upd_valid_d = 1'b1;
      upd_cell_d  = ret_cell;
      upd_addr_d  = ret_addr;
      cnt_d       = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && phase3_ready) begin
          state_d = ST_SWEEP;
          armed_d = 1'b0;
          bank_d  = double_buffer;
          cell_d  = '0;
          addr_d  = '0;
          cnt_d   = '0;
          term_d  = '0;
        end
      end
      ST_SWEEP: begin
        if (cell_cut) begin
          if (cell_q == LAST_CELL) begin
            state_d = ST_DRAIN;
          end else begin
            cell_d = cell_q + CELL_W'(1);
            addr_d = '0;
          end
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pipe_empty && wb_idle) begin
          state_d  = ST_DONE;
          pcount_d = cnt_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      bank_q      <= 1'b0;
      cell_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      term_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_cell_q  <= '0;
      upd_addr_q  <= '0;
      pcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bank_q      <= bank_d;
      cell_q      <= cell_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      term_q      <= term_d;
      upd_valid_q <= upd_valid_d;
      upd_cell_q  <= upd_cell_d;
      upd_addr_q  <= upd_addr_d;
      pcount_q    <= pcount_d;
    end
  end

  assign rd_en          = issue;
  assign rd_cell        = cell_q;
  assign rd_addr        = addr_q;
  assign rd_bank        = bank_q;
  assign wr_bank        = ~bank_q;
  assign upd_valid      = upd_valid_q;
  assign upd_cell       = upd_cell_q;
  assign upd_addr       = upd_addr_q;
  assign phase3_done    = (state_q == ST_DONE);
  assign particle_count = pcount_q;

endmodule

// File: tb/tb_phase3_sweep_unit.sv
// Bench for phase3_sweep_unit: a small cache/datapath environment plus a
// per-cell "occupied prefix" reference model of what each sweep must do.
module tb_phase3_sweep_unit;

  localparam int NC = 4;
  localparam int CD = 8;
  localparam int RL = 2;
  localparam int CW = $clog2(NC);
  localparam int AW = $clog2(CD);
  localparam int NW = $clog2(NC*CD+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          phase3_ready;
  logic          double_buffer;
  logic          phase3_done;
  logic          rd_en;
  logic [CW-1:0] rd_cell;
  logic [AW-1:0] rd_addr;
  logic          rd_bank;
  logic          rd_slot_valid = 1'b0;
  logic          upd_valid;
  logic [CW-1:0] upd_cell;
  logic [AW-1:0] upd_addr;
  logic          wr_bank;
  logic          wb_idle = 1'b1;
  logic [NW-1:0] particle_count;

  phase3_sweep_unit #(.N_CELL(NC), .CELL_DEPTH(CD), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset), .phase3_ready(phase3_ready), .double_buffer(double_buffer),
    .phase3_done(phase3_done), .rd_en(rd_en), .rd_cell(rd_cell), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .rd_slot_valid(rd_slot_valid), .upd_valid(upd_valid),
    .upd_cell(upd_cell), .upd_addr(upd_addr), .wr_bank(wr_bank), .wb_idle(wb_idle),
    .particle_count(particle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment state
  bit occ [2][NC][CD];
  bit hist_en [RL+1];
  bit hist_occ [RL+1];
  int cyc = 0;
  int last_rd = -1000;
  int first_rd = 0;
  int rise_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int bank_err = 0;
  int wb_hold = 0;
  bit exp_bank = 1'b0;
  bit ready_prev = 1'b0;
  int obs_rd[$];
  int obs_upd[$];
  int exp_rd[$];
  int exp_upd[$];
  int exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor, cache model (RL-cycle occupancy return) and datapath idle model.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (phase3_ready === 1'b1 && !ready_prev) rise_cyc = cyc;
    ready_prev = (phase3_ready === 1'b1);
    if (rd_en === 1'b1) begin
      if (obs_rd.size() == 0) first_rd = cyc;
      obs_rd.push_back(int'(rd_cell) * 16 + int'(rd_addr));
      last_rd = cyc;
      if (rd_bank !== exp_bank || wr_bank !== ~exp_bank) bank_err++;
    end
    if (upd_valid === 1'b1) obs_upd.push_back(int'(upd_cell) * 16 + int'(upd_addr));
    if (phase3_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int i = RL; i > 0; i--) begin
      hist_en[i]  = hist_en[i-1];
      hist_occ[i] = hist_occ[i-1];
    end
    hist_en[0]  = (rd_en === 1'b1);
    hist_occ[0] = (rd_en === 1'b1) ? occ[rd_bank][rd_cell][rd_addr] : 1'b0;
    rd_slot_valid = hist_en[RL] ? hist_occ[RL] : 1'($urandom);
    wb_idle = ((cyc - last_rd) >= (RL + 1 + wb_hold));
  end

  // Reference: each cell forwards its occupied prefix; reads continue RL
  // slots past the first empty slot (capped at the cell end).
  task automatic build_expect(input int bank);
    int k;
    int nrd;
    exp_rd.delete();
    exp_upd.delete();
    exp_cnt = 0;
    for (int c = 0; c < NC; c++) begin
      k = CD;
      for (int a = CD - 1; a >= 0; a--) if (!occ[bank][c][a]) k = a;
      for (int a = 0; a < k; a++) begin
        exp_upd.push_back(c * 16 + a);
        exp_cnt++;
      end
      nrd = (k + RL + 1 < CD) ? k + RL + 1 : CD;
      for (int a = 0; a < nrd; a++) exp_rd.push_back(c * 16 + a);
    end
  endtask

  task automatic fill(input int bank, input int empty_odds);
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < CD; a++)
        occ[bank][c][a] = (empty_odds == 0) ? 1'b1 : ($urandom_range(0, empty_odds - 1) != 0);
  endtask

  task automatic run_sweep(input string tag, input int bank, input bit toggle, input int hold);
    build_expect(bank);
    exp_bank = bank[0];
    wb_hold = hold;
    double_buffer = bank[0];
    obs_rd.delete();
    obs_upd.delete();
    done_cnt = 0;
    bank_err = 0;
    phase3_ready = 1'b0;
    @(posedge clk); #1;
    phase3_ready = 1'b1;
    for (int i = 0; i < 800 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (toggle && (i % 5 == 2)) double_buffer = ~double_buffer;
    end
    check({tag, "_done_seen"}, (done_cnt > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_rd_count"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), obs_rd[i], exp_rd[i]);
    check({tag, "_upd_count"}, obs_upd.size(), exp_upd.size());
    for (int i = 0; i < exp_upd.size() && i < obs_upd.size(); i++)
      check($sformatf("%s_upd%0d", tag, i), obs_upd[i], exp_upd[i]);
    check({tag, "_particle_count"}, particle_count, exp_cnt);
    check({tag, "_first_rd_lat"}, first_rd - rise_cyc, 1);
    check({tag, "_done_lat"}, done_cyc - last_rd, RL + 2 + hold);
    check({tag, "_bank_err"}, bank_err, 0);
    check({tag, "_rd_bank_held"}, rd_bank, bank);
    check({tag, "_wr_bank_held"}, wr_bank, 1 - bank);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    phase3_ready = 1'b0;
    double_buffer = 1'b0;
    fill(0, 0);
    fill(1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_cell", rd_cell, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_wr_bank", wr_bank, 1);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_upd_cell", upd_cell, 0);
    check("rst_upd_addr", upd_addr, 0);
    check("rst_done", phase3_done, 0);
    check("rst_pcount", particle_count, 0);

    // Ready rises together with reset release: never sampled low, so no start.
    @(posedge clk); #1;
    reset = 1'b0;
    phase3_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("nostart_rd", obs_rd.size(), 0);
    check("nostart_done", done_cnt, 0);

    // All slots occupied.
    run_sweep("full", 0, 1'b0, 0);
    check("full_pcount32", particle_count, 32);

    // Cell 1: slots 0-2 occupied, slot 3 empty, 4-7 occupied (must be dropped).
    fill(0, 0);
    occ[0][1][3] = 1'b0;
    run_sweep("cut", 0, 1'b0, 0);
    check("cut_pcount27", particle_count, 27);

    // Bank 1 latched, double_buffer toggled during the sweep.
    occ[0][2][1] = 1'b0;
    fill(1, 0);
    run_sweep("bank", 1, 1'b1, 0);

    // Datapath busy 10 extra cycles, then ready left high after done.
    fill(0, 4);
    run_sweep("wbhold", 0, 1'b0, 10);
    n = obs_rd.size();
    repeat (20) @(posedge clk);
    #1;
    check("norestart_rd", obs_rd.size(), n);
    check("norestart_done", done_cnt, 1);

    // Reset in the middle of a bank-1 sweep.
    fill(1, 0);
    exp_bank = 1'b1;
    double_buffer = 1'b1;
    done_cnt = 0;
    obs_rd.delete();
    phase3_ready = 1'b0;
    @(posedge clk); #1;
    phase3_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_sweeping", obs_rd.size() > 0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rd_en", rd_en, 0);
    check("abort_rd_bank", rd_bank, 0);
    check("abort_wr_bank", wr_bank, 1);
    check("abort_upd_valid", upd_valid, 0);
    check("abort_pcount", particle_count, 0);
    check("abort_done", phase3_done, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    fill(0, 0);
    run_sweep("clean", 0, 1'b0, 0);
    check("clean_pcount32", particle_count, 32);

    // Randomized occupancy in both banks.
    for (int r = 0; r < 4; r++) begin
      fill(0, 5);
      fill(1, 5);
      run_sweep($sformatf("rand%0d", r), $urandom_range(0, 1), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase3_sweep_unit.md
# phase3_sweep_unit

Phase-3 (motion update) sequencer; it is the responder side of the control unit's phase handshake. On each phase3_ready rising edge it sweeps every particle slot of every cell in the read bank of the position/velocity caches. It forwards occupied slots to the motion-update datapath, waits for that datapath to drain, then returns a one-cycle phase3_done pulse. Bank selection follows double_buffer, latched at sweep start.

## Interface
Parameters:
- N_CELL, 27: number of cells swept, indices 0..N_CELL-1.
- CELL_DEPTH, 64: slots per cell, addresses 0..CELL_DEPTH-1.
- RD_LAT, 2: fixed cache read latency in cycles (≥1).
- CELL_W = $clog2(N_CELL), ADDR_W = $clog2(CELL_DEPTH), CNT_W = $clog2(N_CELL*CELL_DEPTH+1): derived widths.

Ports:
- clk, in, 1: clock, all logic on rising edge.
- reset, in, 1: asynchronous, active-high.
- phase3_ready, in, 1: phase-3 enable from the control unit.
- double_buffer, in, 1: current bank parity from the control unit.
- phase3_done, out, 1: one-cycle completion pulse.
- rd_en, out, 1: cache read strobe.
- rd_cell, out, CELL_W: read cell index.
- rd_addr, out, ADDR_W: read slot address.
- rd_bank, out, 1: bank being read, latched.
- rd_slot_valid, in, 1: occupancy bit of slot returned RD_LAT cycles after rd_en.
- upd_valid, out, 1: occupied slot forwarded to datapath.
- upd_cell, out, CELL_W; upd_addr, out, ADDR_W: slot identity for upd_valid.
- wr_bank, out, 1: bank the datapath writes; always ~rd_bank.
- wb_idle, in, 1: datapath pipeline empty and all writes retired.
- particle_count, out, CNT_W: occupied slots forwarded in the last completed sweep.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- Arm flag: set whenever phase3_ready is sampled low. IDLE→SWEEP requires armed && phase3_ready. On entry: clear arm, latch rd_bank=double_buffer, cell=0, addr=0, running count=0.
- SWEEP: one read per cycle, rd_en=1. Reads are tagged with cell and addr in an RD_LAT-deep tag shift register.
- Address advance: addr+1. If addr==CELL_DEPTH-1, go to cell+1, addr 0.
- Empty return (rd_slot_valid=0, tag cell == current issue cell): the current cell terminates. The next issued read is cell+1, addr 0.
- Empty return whose tag cell ≠ current issue cell: no issue-side change. That cell is still marked terminated.
- Squash: after an empty return for cell c, every later return tagged c is dropped and produces no upd_valid.
- Occupied, unsquashed return: upd_valid=1 with tag cell/addr; count+1.
- Terminating the last cell, either by empty return or by issuing its last addr: go to DRAIN with rd_en=0.
- DRAIN: wait until the tag pipe holds no outstanding reads and wb_idle=1, then go to DONE.
- DONE: phase3_done=1 for one cycle; particle_count updates with the running count; go to IDLE.
- phase3_ready falling mid-SWEEP/DRAIN is ignored; the sweep completes. double_buffer changes after start are ignored.
- Because arming needs ready low, a ready level still high after done never starts a second sweep.

## Timing
- Reset values: state IDLE, armed 0, all outputs 0 (rd_bank 0, wr_bank 1, particle_count 0), tag pipe cleared. Reset mid-sweep aborts immediately with no done pulse.
- First rd_en occurs 1 cycle after the phase3_ready rising edge is sampled.
- upd_valid is registered: rd_en at cycle t gives upd_valid at t+RD_LAT+1.
- Empty return at cycle t+RD_LAT for a read issued at t: the read issued at t+RD_LAT+1 is cell+1 addr 0. Reads of the same cell issued in t+1..t+RD_LAT are squashed.
- Full sweep with no empty slots: N_CELL*CELL_DEPTH rd_en cycles. Done follows no earlier than RD_LAT+2 cycles after the last rd_en.
- phase3_done is registered and lasts exactly one cycle. The control unit drops ready the following cycle.

## Structure
- Shared md package: state enum, and the N_CELL/CELL_DEPTH defaults used by cache and control.
- One sub-module: read_tag_pipe. It is an RD_LAT-deep shift register of {valid, cell, addr} that provides the outstanding-read-empty indication.

## Test plan
Bench parameters: N_CELL=4, CELL_DEPTH=8, RD_LAT=2.
- Reset: reset → all outputs 0, wr_bank=1. Ready rising with no prior low sample never starts.
- All 32 slots occupied, wb_idle=1 → 32 rd_en, 32 upd_valid in cell/addr order, one phase3_done, particle_count=32.
- Cell 1 has slots 0-2 occupied → cell 1 addr 3,4,5 are read; addr 4,5 are squashed; next read is cell 2 addr 0. Count=27.
- double_buffer=1 at start, toggled mid-sweep → rd_bank=1 and wr_bank=0 for the whole sweep.
- wb_idle held low 10 cycles after the tag pipe drains → done delayed by exactly 10 cycles. Ready held high after done → no restart until a low then high.
- Reset asserted mid-SWEEP → outputs 0 next cycle, no done. A new ready low→high starts a full clean sweep.
